// File: rtl/drop_timer_ctrl_pkg.sv
// Shared definitions for the drop timer and the seconds counter it listens to.
package drop_timer_ctrl_pkg;

  typedef enum logic {
    StCount = 1'b0,
    StReq   = 1'b1
  } state_e;

  localparam int unsigned SecW    = 5;
  // Last value of the seconds counter before it wraps to 0.
  localparam int unsigned SecWrap = 23;

endpackage

// File: rtl/drop_timer_ctrl_sec_to_bcd.sv
// Combinational binary-to-BCD conversion of a seconds value (0..31 -> tens 0..3, ones 0..9).
module sec_to_bcd
  import drop_timer_ctrl_pkg::*;
#(
  parameter int unsigned SEC_W = SecW
) (
  input  logic [SEC_W-1:0] i_value,
  output logic [1:0]       o_tens,
  output logic [3:0]       o_ones
);

  logic [SEC_W-1:0] w_rem;

  // Subtract the largest multiple of ten; 2 tens bits are enough for a 5-bit input.
  always_comb begin
    o_tens = 2'd0;
    w_rem  = i_value;
    if (i_value >= SEC_W'(30)) begin
      o_tens = 2'd3;
      w_rem  = i_value - SEC_W'(30);
    end else if (i_value >= SEC_W'(20)) begin
      o_tens = 2'd2;
      w_rem  = i_value - SEC_W'(20);
    end else if (i_value >= SEC_W'(10)) begin
      o_tens = 2'd1;
      w_rem  = i_value - SEC_W'(10);
    end
    o_ones = w_rem[3:0];
  end

endmodule

// File: rtl/drop_timer_ctrl.sv
// Turns seconds-counter ticks into level-dependent gravity drop requests with a req/ack
// handshake, a sticky stall flag, a counter force-reset pulse and registered BCD seconds.
module drop_timer_ctrl
  import drop_timer_ctrl_pkg::*;
#(
  parameter int unsigned SEC_W        = SecW,
  parameter int unsigned INTERVAL_MAX = 8,
  parameter int unsigned ACK_TIMEOUT  = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [SEC_W-1:0] i_seconds_in,
  input  logic [2:0]       i_level,
  input  logic             i_new_piece,
  input  logic             i_drop_ack,
  output logic             o_force_reset,
  output logic             o_drop_req,
  output logic             o_stall,
  output logic [1:0]       o_sec_tens,
  output logic [3:0]       o_sec_ones
);

  localparam logic [3:0] CntMax     = 4'hF;
  localparam logic [3:0] AckTimeout = 4'(ACK_TIMEOUT);

  state_e           r_state, w_state_d;
  logic [3:0]       r_elapsed, w_elapsed_d;
  logic [3:0]       r_wait_cnt, w_wait_d;
  logic [SEC_W-1:0] r_prev_sec;
  logic             r_mask;
  logic             r_force_reset;
  logic             r_stall, w_stall_d;
  logic [1:0]       r_sec_tens;
  logic [3:0]       r_sec_ones;

  logic             w_tick;
  logic             w_reach;
  int               w_diff;
  logic [3:0]       w_interval;
  logic [3:0]       w_elapsed_inc;
  logic [3:0]       w_wait_inc;
  logic [1:0]       w_tens;
  logic [3:0]       w_ones;

  sec_to_bcd #(
    .SEC_W (SEC_W)
  ) u_sec_to_bcd (
    .i_value (i_seconds_in),
    .o_tens  (w_tens),
    .o_ones  (w_ones)
  );

  always_comb begin
    w_interval = 4'd1;
    w_diff     = int'(INTERVAL_MAX) - int'(i_level);
    if (w_diff >= 15) begin
      w_interval = CntMax;
    end else if (w_diff > 1) begin
      w_interval = 4'(w_diff);
    end
  end

  // The counter's forced return to 0 lands while r_mask is set and is not a tick.
  assign w_tick        = (i_seconds_in != r_prev_sec) && !r_mask;
  assign w_elapsed_inc = (r_elapsed == CntMax) ? CntMax : r_elapsed + 4'd1;
  assign w_wait_inc    = (r_wait_cnt == CntMax) ? CntMax : r_wait_cnt + 4'd1;
  assign w_reach       = ({1'b0, r_elapsed} + 5'd1) >= {1'b0, w_interval};

  always_comb begin
    w_state_d   = r_state;
    w_elapsed_d = r_elapsed;
    w_wait_d    = r_wait_cnt;
    if (i_new_piece) begin
      w_state_d   = StCount;
      w_elapsed_d = 4'd0;
      w_wait_d    = 4'd0;
    end else begin
      unique case (r_state)
        StCount: begin
          if (w_tick) begin
            if (w_reach) begin
              w_state_d   = StReq;
              w_elapsed_d = 4'd0;
            end else begin
              w_elapsed_d = w_elapsed_inc;
            end
          end
        end
        StReq: begin
          // An ack in the same cycle as a tick wins; the tick is dropped.
          if (i_drop_ack) begin
            w_state_d   = StCount;
            w_elapsed_d = 4'd0;
            w_wait_d    = 4'd0;
          end else if (w_tick) begin
            w_wait_d = w_wait_inc;
          end
        end
      endcase
    end
    w_stall_d = r_stall | (w_wait_d >= AckTimeout);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state       <= StCount;
      r_elapsed     <= 4'd0;
      r_wait_cnt    <= 4'd0;
      r_prev_sec    <= '0;
      r_mask        <= 1'b0;
      r_force_reset <= 1'b0;
      r_stall       <= 1'b0;
      r_sec_tens    <= 2'd0;
      r_sec_ones    <= 4'd0;
    end else begin
      r_state       <= w_state_d;
      r_elapsed     <= w_elapsed_d;
      r_wait_cnt    <= w_wait_d;
      r_prev_sec    <= i_seconds_in;
      r_mask        <= r_force_reset;
      r_force_reset <= i_new_piece;
      r_stall       <= w_stall_d;
      r_sec_tens    <= w_tens;
      r_sec_ones    <= w_ones;
    end
  end

  assign o_drop_req    = (r_state == StReq);
  assign o_force_reset = r_force_reset;
  assign o_stall       = r_stall;
  assign o_sec_tens    = r_sec_tens;
  assign o_sec_ones    = r_sec_ones;

endmodule
